// File: rtl/conv_pkg.sv
// Geometry helpers shared by the line buffer datapath and controller
// so both sides agree on padded sizes, window spans and blank points.
package conv_pkg;

    function automatic int total_dim(int in_dim, int pad);
        return in_dim + 2 * pad;
    endfunction

    function automatic int window_dim(int k, int d);
        return d * (k - 1) + 1;
    endfunction

    function automatic int cnt_w(int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Kernel points that can ever overlap top padding or the stale
    // row start; they form a raster prefix of the kernel.
    function automatic int num_blank_pts(int k0, int k1, int d0, int d1,
                                         int p0, int p1);
        int full_rows;
        int part;
        full_rows = (p0 + d0 - 1) / d0;
        if (full_rows >= k0) return k0 * k1;
        part = 0;
        if (p0 % d0 == 0) begin
            part = (p1 + d1 - 1) / d1;
            if (part > k1) part = k1;
        end
        return full_rows * k1 + part;
    endfunction

endpackage

// File: rtl/line_buffer_controller.sv
// Raster walk over the padded frame driving line buffer shift, padding
// injection, window valid/last and the per-kernel-point blank mask.
module line_buffer_controller
    import conv_pkg::*;
#(
    parameter int IN_HEIGHT  = 256,
    parameter int IN_WIDTH   = 512,
    parameter int KERNEL_0   = 3,
    parameter int KERNEL_1   = 3,
    parameter int DILATION_0 = 2,
    parameter int DILATION_1 = 2,
    parameter int PADDING_0  = 2,
    parameter int PADDING_1  = 2,
    parameter int STRIDE_0   = 1,
    parameter int STRIDE_1   = 1,
    localparam int BLANK_PTS = num_blank_pts(KERNEL_0, KERNEL_1,
        DILATION_0, DILATION_1, PADDING_0, PADDING_1),
    localparam int BLANK_PTS_SAFE = (BLANK_PTS > 0) ? BLANK_PTS : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_valid,
    output logic                      i_ready,
    output logic                      shift,
    output logic                      is_padding,
    output logic [BLANK_PTS_SAFE-1:0] out_blank,
    output logic                      o_valid,
    output logic                      o_last,
    input  logic                      o_ready
);

    localparam int TOTAL_H  = total_dim(IN_HEIGHT, PADDING_0);
    localparam int TOTAL_W  = total_dim(IN_WIDTH, PADDING_1);
    localparam int WINDOW_0 = window_dim(KERNEL_0, DILATION_0);
    localparam int WINDOW_1 = window_dim(KERNEL_1, DILATION_1);
    localparam int RW  = cnt_w(TOTAL_H);
    localparam int CW  = cnt_w(TOTAL_W);
    localparam int SW0 = cnt_w(STRIDE_0);
    localparam int SW1 = cnt_w(STRIDE_1);
    localparam int ROW_FIRST =
        (WINDOW_0 - 1 > PADDING_0) ? WINDOW_0 - 1 : PADDING_0;
    localparam int LAST_R =
        TOTAL_H - 1 - ((TOTAL_H - WINDOW_0) % STRIDE_0);
    localparam int LAST_C =
        TOTAL_W - 1 - ((TOTAL_W - WINDOW_1) % STRIDE_1);
    localparam logic [RW-1:0]  R_START = RW'(PADDING_0);
    localparam logic [RW-1:0]  R_ONE   = RW'(1);
    localparam logic [CW-1:0]  C_ONE   = CW'(1);
    localparam logic [SW0-1:0] RPH_MAX = SW0'(STRIDE_0 - 1);
    localparam logic [SW1-1:0] CPH_MAX = SW1'(STRIDE_1 - 1);
    localparam logic [SW0-1:0] RPH_ONE = SW0'(1);
    localparam logic [SW1-1:0] CPH_ONE = SW1'(1);

    logic [RW-1:0]  r_q, r_d;
    logic [CW-1:0]  c_q, c_d;
    logic [SW0-1:0] rph_q, rph_d;
    logic [SW1-1:0] cph_q, cph_d;
    logic           o_valid_q, o_last_q;
    logic [BLANK_PTS_SAFE-1:0] blank_q, blank_d;
    logic           pad, stall, complete, at_last;
    int             r_i, c_i;

    assign r_i = int'(r_q);
    assign c_i = int'(c_q);

    assign pad = (c_i < PADDING_1) || (c_i >= PADDING_1 + IN_WIDTH)
              || (r_i >= PADDING_0 + IN_HEIGHT);
    assign stall      = o_valid_q & ~o_ready;
    assign shift      = ~stall & (pad | i_valid);
    assign i_ready    = ~stall & ~pad;
    assign is_padding = pad;

    assign complete = shift
                   && (r_i >= WINDOW_0 - 1) && (c_i >= WINDOW_1 - 1)
                   && (rph_q == '0) && (cph_q == '0);
    assign at_last  = (r_i == LAST_R) && (c_i == LAST_C);

    always_comb begin
        r_d   = r_q;
        c_d   = c_q;
        rph_d = rph_q;
        cph_d = cph_q;
        if (shift) begin
            if (c_i == TOTAL_W - 1) begin
                c_d   = '0;
                cph_d = '0;
                if (r_i == TOTAL_H - 1) begin
                    r_d   = R_START;
                    rph_d = '0;
                end else begin
                    r_d = r_q + R_ONE;
                    if (r_i < ROW_FIRST)
                        rph_d = '0;
                    else
                        rph_d = (rph_q == RPH_MAX) ? '0 : rph_q + RPH_ONE;
                end
            end else begin
                c_d = c_q + C_ONE;
                if (c_i < WINDOW_1 - 1)
                    cph_d = '0;
                else
                    cph_d = (cph_q == CPH_MAX) ? '0 : cph_q + CPH_ONE;
            end
        end
    end

    // Mask from the top-left corner of the window completing now.
    always_comb begin
        int r0, c0, ri, cj;
        blank_d = '0;
        r0 = r_i - WINDOW_0 + 1;
        c0 = c_i - WINDOW_1 + 1;
        for (int p = 0; p < BLANK_PTS; p++) begin
            ri = r0 + (p / KERNEL_1) * DILATION_0;
            cj = c0 + (p % KERNEL_1) * DILATION_1;
            blank_d[p] = (ri < PADDING_0)
                      || ((ri == PADDING_0) && (cj < PADDING_1));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q       <= R_START;
            c_q       <= '0;
            rph_q     <= '0;
            cph_q     <= '0;
            o_valid_q <= 1'b0;
            o_last_q  <= 1'b0;
            blank_q   <= '0;
        end else begin
            r_q   <= r_d;
            c_q   <= c_d;
            rph_q <= rph_d;
            cph_q <= cph_d;
            if (!stall) begin
                o_valid_q <= complete;
                o_last_q  <= complete & at_last;
                if (complete) blank_q <= blank_d;
            end
        end
    end

    assign o_valid   = o_valid_q;
    assign o_last    = o_last_q;
    assign out_blank = blank_q;

endmodule

// File: tb/tb_line_buffer_controller.sv
// Scoreboard bench: 4x4 frame, 3x3 kernel, pad 1, strides 1 and 2.
module tb_line_buffer_controller;

    typedef struct {
        logic [3:0] mask;
        logic       last;
    } win_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst0_n, iv0, ir0, sh0, pad0, ov0, ol0, or0;
    logic [3:0] ob0;
    logic       rst1_n, iv1, ir1, sh1, pad1, ov1, ol1, or1;
    logic [3:0] ob1;

    win_t q0[$];
    win_t q1[$];
    win_t e0, e1;
    int vectors = 0;
    int errors  = 0;
    int shc0, popc0, winc0, first0;
    int shc1, popc1, winc1, first1;

    line_buffer_controller #(
        .IN_HEIGHT(4), .IN_WIDTH(4), .KERNEL_0(3), .KERNEL_1(3),
        .DILATION_0(1), .DILATION_1(1), .PADDING_0(1), .PADDING_1(1),
        .STRIDE_0(1), .STRIDE_1(1)
    ) u0 (
        .clk(clk), .rst_n(rst0_n), .i_valid(iv0), .i_ready(ir0),
        .shift(sh0), .is_padding(pad0), .out_blank(ob0),
        .o_valid(ov0), .o_last(ol0), .o_ready(or0)
    );

    line_buffer_controller #(
        .IN_HEIGHT(4), .IN_WIDTH(4), .KERNEL_0(3), .KERNEL_1(3),
        .DILATION_0(1), .DILATION_1(1), .PADDING_0(1), .PADDING_1(1),
        .STRIDE_0(2), .STRIDE_1(2)
    ) u1 (
        .clk(clk), .rst_n(rst1_n), .i_valid(iv1), .i_ready(ir1),
        .shift(sh1), .is_padding(pad1), .out_blank(ob1),
        .o_valid(ov1), .o_last(ol1), .o_ready(or1)
    );

    always @(negedge clk) if (rst0_n) begin
        if (ov0 && first0 < 0) first0 = shc0;
        if (ov0 && or0) begin
            winc0++;
            vectors++;
            if (q0.size() == 0) begin
                errors++;
                $display("FAIL win0_extra idx=%0d got mask=%b last=%b want none",
                         winc0, ob0, ol0);
            end else begin
                e0 = q0.pop_front();
                if (ob0 !== e0.mask || ol0 !== e0.last) begin
                    errors++;
                    $display("FAIL win0 idx=%0d got mask=%b last=%b want mask=%b last=%b",
                             winc0, ob0, ol0, e0.mask, e0.last);
                end
            end
        end
        if (sh0) shc0++;
        if (iv0 && ir0) popc0++;
    end

    always @(negedge clk) if (rst1_n) begin
        if (ov1 && first1 < 0) first1 = shc1;
        if (ov1 && or1) begin
            winc1++;
            vectors++;
            if (q1.size() == 0) begin
                errors++;
                $display("FAIL win1_extra idx=%0d got mask=%b last=%b want none",
                         winc1, ob1, ol1);
            end else begin
                e1 = q1.pop_front();
                if (ob1 !== e1.mask || ol1 !== e1.last) begin
                    errors++;
                    $display("FAIL win1 idx=%0d got mask=%b last=%b want mask=%b last=%b",
                             winc1, ob1, ol1, e1.mask, e1.last);
                end
            end
        end
        if (sh1) shc1++;
        if (iv1 && ir1) popc1++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected stride-1 windows: bottom-right (r,c) over rows/cols 2..5.
    task automatic push_base();
        win_t w;
        for (int r = 2; r < 6; r++) begin
            for (int c = 2; c < 6; c++) begin
                for (int p = 0; p < 4; p++) begin
                    int ri, cj;
                    ri = r - 2 + p / 3;
                    cj = c - 2 + p % 3;
                    w.mask[p] = (ri < 1) || (ri == 1 && cj < 1);
                end
                w.last = (r == 5 && c == 5);
                q0.push_back(w);
            end
        end
    endtask

    task automatic begin_frame0(input logic iv);
        rst0_n = 1'b0;
        step();
        shc0 = 0; popc0 = 0; winc0 = 0; first0 = -1;
        q0.delete();
        push_base();
        iv0 = iv;
        or0 = 1'b1;
        rst0_n = 1'b1;
    endtask

    task automatic wait_shifts0(input int n, input string tag);
        int k;
        k = 0;
        while (shc0 < n && k < 300) begin
            step();
            k++;
        end
        if (shc0 < n) begin
            vectors++;
            errors++;
            $display("FAIL %s_timeout got shifts=%0d want %0d", tag, shc0, n);
        end
    endtask

    task automatic test_reset();
        rst0_n = 1'b0; iv0 = 1'b0; or0 = 1'b1;
        step();
        vectors++;
        if ({ov0, ol0, ob0} !== 6'b0) begin
            errors++;
            $display("FAIL reset_regs got=%b want=000000", {ov0, ol0, ob0});
        end
        vectors++;
        if ({sh0, ir0, pad0} !== 3'b101) begin
            errors++;
            $display("FAIL reset_comb got=%b want=101", {sh0, ir0, pad0});
        end
        iv0 = 1'b1;
        #1;
        vectors++;
        if ({sh0, ir0, pad0} !== 3'b101) begin
            errors++;
            $display("FAIL reset_comb_iv got=%b want=101", {sh0, ir0, pad0});
        end
    endtask

    task automatic test_full_frame();
        begin_frame0(1'b1);
        wait_shifts0(30, "full");
        vectors++;
        if (popc0 !== 16) begin
            errors++;
            $display("FAIL full_pops got=%0d want=16", popc0);
        end
        vectors++;
        if (first0 !== 9) begin
            errors++;
            $display("FAIL full_first got=%0d want=9", first0);
        end
        vectors++;
        if ({pad0, sh0, ir0, ov0, ol0} !== 5'b11011) begin
            errors++;
            $display("FAIL full_wrap got=%b want=11011", {pad0, sh0, ir0, ov0, ol0});
        end
        step();
        vectors++;
        if ({pad0, ir0, ov0, ol0} !== 4'b0100) begin
            errors++;
            $display("FAIL full_next got=%b want=0100", {pad0, ir0, ov0, ol0});
        end
        vectors++;
        if (winc0 !== 16 || q0.size() !== 0) begin
            errors++;
            $display("FAIL full_wins got=%0d left=%0d want 16/0", winc0, q0.size());
        end
        rst0_n = 1'b0;
    endtask

    task automatic test_stall();
        logic [3:0] hold;
        int k;
        begin_frame0(1'b1);
        k = 0;
        while (!ov0 && k < 50) begin
            step();
            k++;
        end
        or0 = 1'b0;
        hold = ob0;
        vectors++;
        if (hold !== 4'b1111 || shc0 !== 9) begin
            errors++;
            $display("FAIL stall_start got mask=%b shifts=%0d want 1111/9", hold, shc0);
        end
        for (int i = 0; i < 5; i++) begin
            #1;
            vectors++;
            if ({sh0, ir0, ov0} !== 3'b001 || ob0 !== hold) begin
                errors++;
                $display("FAIL stall_hold cyc=%0d got=%b mask=%b want=001 mask=%b",
                         i, {sh0, ir0, ov0}, ob0, hold);
            end
            step();
        end
        vectors++;
        if (shc0 !== 9) begin
            errors++;
            $display("FAIL stall_pos got shifts=%0d want 9", shc0);
        end
        or0 = 1'b1;
        wait_shifts0(30, "stall");
        step();
        vectors++;
        if (winc0 !== 16 || q0.size() !== 0 || popc0 !== 16) begin
            errors++;
            $display("FAIL stall_wins got=%0d left=%0d pops=%0d want 16/0/16",
                     winc0, q0.size(), popc0);
        end
        rst0_n = 1'b0;
    endtask

    task automatic test_ivalid_toggle();
        int k;
        begin_frame0(1'b0);
        k = 0;
        while (k < 200) begin
            step();
            k++;
            if (shc0 >= 30) break;
            iv0 = ~iv0;
            #1;
            vectors++;
            if (sh0 !== (pad0 | iv0)) begin
                errors++;
                $display("FAIL toggle_shift cyc=%0d got=%b want=%b pad=%b",
                         k, sh0, pad0 | iv0, pad0);
            end
        end
        vectors++;
        if (shc0 !== 30 || popc0 !== 16) begin
            errors++;
            $display("FAIL toggle_counts got shifts=%0d pops=%0d want 30/16",
                     shc0, popc0);
        end
        iv0 = 1'b1;
        step();
        vectors++;
        if (winc0 !== 16 || q0.size() !== 0) begin
            errors++;
            $display("FAIL toggle_wins got=%0d left=%0d want 16/0", winc0, q0.size());
        end
        rst0_n = 1'b0;
    endtask

    task automatic test_stride2();
        win_t w;
        int k;
        rst1_n = 1'b0;
        step();
        shc1 = 0; popc1 = 0; winc1 = 0; first1 = -1;
        q1.delete();
        w.last = 1'b0;
        w.mask = 4'b1111; q1.push_back(w);
        w.mask = 4'b0111; q1.push_back(w);
        w.mask = 4'b0000; q1.push_back(w);
        w.last = 1'b1;    q1.push_back(w);
        iv1 = 1'b1;
        or1 = 1'b1;
        rst1_n = 1'b1;
        k = 0;
        while (shc1 < 30 && k < 300) begin
            step();
            k++;
        end
        step();
        vectors++;
        if (winc1 !== 4 || q1.size() !== 0 || popc1 !== 16) begin
            errors++;
            $display("FAIL s2_wins got=%0d left=%0d pops=%0d want 4/0/16",
                     winc1, q1.size(), popc1);
        end
        vectors++;
        if (first1 !== 9) begin
            errors++;
            $display("FAIL s2_first got=%0d want=9", first1);
        end
        rst1_n = 1'b0;
    endtask

    task automatic test_reset_midframe();
        begin_frame0(1'b1);
        wait_shifts0(16, "mid");
        vectors++;
        if (ov0 !== 1'b1) begin
            errors++;
            $display("FAIL mid_pre got o_valid=%b want=1", ov0);
        end
        rst0_n = 1'b0;
        #1;
        vectors++;
        if ({ov0, ol0} !== 2'b00) begin
            errors++;
            $display("FAIL mid_async got=%b want=00", {ov0, ol0});
        end
        step();
        shc0 = 0; popc0 = 0; winc0 = 0; first0 = -1;
        q0.delete();
        push_base();
        rst0_n = 1'b1;
        wait_shifts0(30, "mid");
        vectors++;
        if (first0 !== 9) begin
            errors++;
            $display("FAIL mid_first got=%0d want=9", first0);
        end
        step();
        vectors++;
        if (winc0 !== 16 || q0.size() !== 0) begin
            errors++;
            $display("FAIL mid_wins got=%0d left=%0d want 16/0", winc0, q0.size());
        end
        rst0_n = 1'b0;
    endtask

    initial begin
        rst0_n = 1'b0; iv0 = 1'b0; or0 = 1'b1;
        rst1_n = 1'b0; iv1 = 1'b0; or1 = 1'b1;
        shc0 = 0; popc0 = 0; winc0 = 0; first0 = -1;
        shc1 = 0; popc1 = 0; winc1 = 0; first1 = -1;
        step();
        test_reset();
        test_full_frame();
        test_stall();
        test_ivalid_toggle();
        test_stride2();
        test_reset_midframe();
        step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule
